// File: rtl/uart_pkg.sv
// Shared types and constants for the target-report UART frame builder.
// Frame length depends on UART_PACK_CHKSUM_EN (16 bytes with checksum, 15 without).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT_H = 2'd2,
    ST_WAIT_L = 2'd3
  } hs_state_t;

  // 43-bit target word layout
  localparam int POS_W     = 43;
  localparam int VALID_BIT = 42;
  localparam int X_MSB     = 41;
  localparam int X_LSB     = 31;
  localparam int Y_MSB     = 30;
  localparam int Y_LSB     = 20;
  localparam int W_MSB     = 19;
  localparam int W_LSB     = 10;
  localparam int H_MSB     = 9;
  localparam int H_LSB     = 0;

  localparam int FRAME_LEN_NOCHK = 15;
`ifdef UART_PACK_CHKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_NOCHK + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_NOCHK;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  localparam logic [7:0] DEF_HDR0 = 8'hA5;
  localparam logic [7:0] DEF_HDR1 = 8'h5A;

  // Zero-extend a target word to six bytes, fields kept in their wire order.
  function automatic logic [47:0] pos_ext(input logic [POS_W-1:0] p);
    return {5'b0, p[VALID_BIT], p[X_MSB:X_LSB], p[Y_MSB:Y_LSB],
            p[W_MSB:W_LSB], p[H_MSB:H_LSB]};
  endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// Per-byte pulse-and-wait engine towards uart_tx: issue one pulse, wait for
// busy to rise (or BUSY_TO cycles), then wait for busy to fall.
module uart_byte_handshake
  import uart_pkg::*;
#(
  parameter int BUSY_TO = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic last,
  input  logic tx_busy,
  output logic tx_pluse,
  output logic issue,
  output logic byte_done,
  output logic frame_done,
  output logic active
);

  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

  hs_state_t state, state_nxt;
  logic [TW-1:0] timer;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    byte_done = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SEND;
      ST_SEND:   if (!tx_busy) begin
                   issue     = 1'b1;
                   state_nxt = ST_WAIT_H;
                 end
      ST_WAIT_H: if (tx_busy || timer == TO_LAST) state_nxt = ST_WAIT_L;
      ST_WAIT_L: if (!tx_busy) begin
                   byte_done = 1'b1;
                   state_nxt = last ? ST_IDLE : ST_SEND;
                 end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign frame_done = byte_done && last;
  assign active     = (state != ST_IDLE);

  // Timer counts WAIT_H cycles since the pulse; WAIT_H exits before it can wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx_pluse <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= state_nxt;
      tx_pluse <= issue;
      if (issue)
        timer <= '0;
      else if (state == ST_WAIT_H)
        timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/uart_target_packer.sv
// Snapshots two target words on frame sync and streams them to uart_tx as one
// framed packet; checksum byte is appended when UART_PACK_CHKSUM_EN is defined.
module uart_target_packer
  import uart_pkg::*;
#(
  parameter logic [7:0] HDR0    = DEF_HDR0,
  parameter logic [7:0] HDR1    = DEF_HDR1,
  parameter int         BUSY_TO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       r_vsync_i,
  input  logic [POS_W-1:0] target_pos_out1,
  input  logic [POS_W-1:0] target_pos_out2,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_pluse,
  output logic             frame_busy,
  output logic [7:0]       drop_cnt
);

  logic             trigger, start, active, issue, byte_done, frame_done, last;
  logic [POS_W-1:0] snap1, snap2;
  logic [3:0]       byte_idx;
  logic [7:0]       seq;
  logic [47:0]      ext1, ext2;
  logic [7:0]       frame_bytes [16];

  assign trigger    = (r_vsync_i == 2'b01);
  assign start      = trigger && !active;
  assign last       = (byte_idx == LAST_IDX);
  assign ext1       = pos_ext(snap1);
  assign ext2       = pos_ext(snap2);
  assign frame_busy = active;

  uart_byte_handshake #(
    .BUSY_TO (BUSY_TO)
  ) u_hs (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .last       (last),
    .tx_busy    (tx_busy),
    .tx_pluse   (tx_pluse),
    .issue      (issue),
    .byte_done  (byte_done),
    .frame_done (frame_done),
    .active     (active)
  );

`ifdef UART_PACK_CHKSUM_EN
  logic [7:0] chk;
  always_comb begin
    chk = seq;
    for (int k = 0; k < 6; k++)
      chk = chk + ext1[8*k +: 8] + ext2[8*k +: 8];
  end
`endif

  always_comb begin
    frame_bytes[0] = HDR0;
    frame_bytes[1] = HDR1;
    frame_bytes[2] = seq;
    for (int k = 0; k < 6; k++) begin
      frame_bytes[3+k] = ext1[8*(5-k) +: 8];
      frame_bytes[9+k] = ext2[8*(5-k) +: 8];
    end
`ifdef UART_PACK_CHKSUM_EN
    frame_bytes[15] = chk;
`else
    frame_bytes[15] = 8'h00;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap1    <= '0;
      snap2    <= '0;
      byte_idx <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      tx_data  <= '0;
    end else begin
      if (start) begin
        snap1    <= target_pos_out1;
        snap2    <= target_pos_out2;
        byte_idx <= '0;
      end else if (byte_done) begin
        byte_idx <= last ? 4'd0 : byte_idx + 4'd1;
      end
      if (frame_done)
        seq <= seq + 8'd1;
      // A trigger while any frame state is active (including its final cycle) is dropped.
      if (trigger && active && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (issue)
        tx_data <= frame_bytes[byte_idx];
    end
  end

endmodule

// File: tb/tb_uart_target_packer.sv
// Self-checking bench for uart_target_packer with a behavioural uart_tx model.
module tb_uart_target_packer;

  localparam int BUSY_TO = 8;
`ifdef UART_PACK_CHKSUM_EN
  localparam int FLEN = 16;
`else
  localparam int FLEN = 15;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  r_vsync_i = 2'b00;
  logic [42:0] t1 = '0;
  logic [42:0] t2 = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_pluse;
  logic        frame_busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  uart_target_packer #(
    .HDR0    (8'hA5),
    .HDR1    (8'h5A),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .r_vsync_i       (r_vsync_i),
    .target_pos_out1 (t1),
    .target_pos_out2 (t2),
    .tx_busy         (tx_busy),
    .tx_data         (tx_data),
    .tx_pluse        (tx_pluse),
    .frame_busy      (frame_busy),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy rises the cycle after a pulse and stays high 3 cycles.
  logic uart_dead = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_pluse && !tx_busy && !uart_dead) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 3;
    end else if (tx_busy) begin
      if (busy_cnt <= 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  int         cyc = 0;
  logic       prev_pluse = 1'b0;
  logic [7:0] cap_q[$];
  int         cap_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_pluse) begin
      cap_q.push_back(tx_data);
      cap_cyc.push_back(cyc);
      checks++;
      if (tx_busy || prev_pluse) begin
        errors++;
        $display("FAIL pulse_protocol: busy=%0b prev_pulse=%0b, required 0 and 0", tx_busy, prev_pluse);
      end
    end
    prev_pluse = tx_pluse;
  end

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1 r_vsync_i = 2'b01;
    @(posedge clk); #1 r_vsync_i = 2'b00;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (frame_busy) begin
      errors++;
      $display("FAIL %s frame_timeout: frame_busy=%0b expected 0", tag, frame_busy);
    end
  endtask

  task automatic run_frame(input string tag, input logic [42:0] a, input logic [42:0] b);
    t1 = a;
    t2 = b;
    cap_q.delete();
    cap_cyc.delete();
    pulse_trigger();
    check_int({tag, " frame_busy_n1"}, int'(frame_busy), 1);
    check_int({tag, " no_pulse_n1"}, int'(tx_pluse), 0);
    @(posedge clk); #1;
    check_int({tag, " first_pulse_n2"}, int'(tx_pluse), 1);
    check8({tag, " first_data_n2"}, tx_data, 8'hA5);
    wait_frame(tag);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] s, input logic [47:0] b1,
                             input logic [47:0] b2, input logic [7:0] c);
    logic [7:0] want [16];
    want[0] = 8'hA5;
    want[1] = 8'h5A;
    want[2] = s;
    for (int k = 0; k < 6; k++) begin
      want[3+k] = b1[8*(5-k) +: 8];
      want[9+k] = b2[8*(5-k) +: 8];
    end
    want[15] = c;
    check_int({tag, " length"}, cap_q.size(), FLEN);
    for (int i = 0; i < FLEN; i++)
      if (i < cap_q.size())
        check8($sformatf("%s byte%0d", tag, i), cap_q[i], want[i]);
  endtask

  typedef struct {
    logic [42:0] t1;
    logic [42:0] t2;
    logic [7:0]  seq;
    logic [47:0] b1;
    logic [47:0] b2;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n;
    vecs[0].t1 = {1'b1, 11'd100, 11'd200, 10'd16, 10'd32};
    vecs[0].t2 = '0;
    vecs[0].seq = 8'h00; vecs[0].b1 = 48'h04320C804020; vecs[0].b2 = 48'h0; vecs[0].chk = 8'h22;
    vecs[1].t1 = 43'h7FF_FFFF_FFFF;
    vecs[1].t2 = {1'b0, 11'd1, 11'd0, 10'd0, 10'd0};
    vecs[1].seq = 8'h01; vecs[1].b1 = 48'h07FFFFFFFFFF; vecs[1].b2 = 48'h000080000000; vecs[1].chk = 8'h83;
    vecs[2].t1 = {1'b0, 11'd0, 11'd0, 10'd0, 10'h3FF};
    vecs[2].t2 = {1'b1, 11'd0, 11'h7FF, 10'd0, 10'd0};
    vecs[2].seq = 8'h02; vecs[2].b1 = 48'h0000000003FF; vecs[2].b2 = 48'h04007FF00000; vecs[2].chk = 8'h77;
    vecs[3].t1 = {1'b0, 11'd0, 11'd0, 10'd1, 10'd1};
    vecs[3].t2 = 43'h7FF_FFFF_FFFF;
    vecs[3].seq = 8'h03; vecs[3].b1 = 48'h000000000401; vecs[3].b2 = 48'h07FFFFFFFFFF; vecs[3].chk = 8'h0A;

    // Reset state
    #12;
    check8("rst tx_data", tx_data, 8'h00);
    check_int("rst tx_pluse", int'(tx_pluse), 0);
    check_int("rst frame_busy", int'(frame_busy), 0);
    check8("rst drop_cnt", drop_cnt, 8'h00);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].t1, vecs[i].t2);
      check_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].b1, vecs[i].b2, vecs[i].chk);
    end

    // Second trigger mid-frame is dropped; snapshot ignores input changes.
    t1 = vecs[0].t1; t2 = vecs[0].t2;
    cap_q.delete(); cap_cyc.delete();
    pulse_trigger();
    n = 0;
    while (cap_q.size() < 5 && n < 500) begin @(posedge clk); n++; end
    pulse_trigger();
    check8("drop cnt_now", drop_cnt, 8'h01);
    t1 = 43'h155_5555_5555; t2 = 43'h2AA_AAAA_AAAA;
    wait_frame("drop");
    check_frame("drop", 8'h04, vecs[0].b1, vecs[0].b2, 8'h26);
    check8("drop cnt_after", drop_cnt, 8'h01);
    repeat (60) @(posedge clk);
    #1;
    check_int("drop no_second_frame", cap_q.size(), FLEN);
    check_int("drop idle", int'(frame_busy), 0);

    // Transmitter never raises busy: pulses spaced by the timeout.
    uart_dead = 1'b1;
    run_frame("timeout", '0, '0);
    check_frame("timeout", 8'h05, 48'h0, 48'h0, 8'h05);
    for (int i = 1; i < FLEN; i++)
      if (i < cap_cyc.size())
        check_int($sformatf("timeout gap%0d", i), cap_cyc[i] - cap_cyc[i-1], BUSY_TO + 2);
    uart_dead = 1'b0;
    repeat (4) @(posedge clk);

    // Sequence counter wraps 255 -> 0
    for (int s = 6; s < 256; s++) begin
      run_frame("wrap", '0, '0);
      check8($sformatf("wrap seq%0d", s), (cap_q.size() > 2) ? cap_q[2] : 8'hXX, 8'(s));
    end
    run_frame("wrap0", '0, '0);
    check_frame("wrap0", 8'h00, 48'h0, 48'h0, 8'h00);

    // Reset in the middle of a frame
    t1 = vecs[0].t1; t2 = vecs[0].t2;
    cap_q.delete(); cap_cyc.delete();
    pulse_trigger();
    n = 0;
    while (cap_q.size() < 6 && n < 500) begin @(posedge clk); n++; end
    #1 reset = 1'b0;
    #1;
    check_int("midrst tx_pluse", int'(tx_pluse), 0);
    check_int("midrst frame_busy", int'(frame_busy), 0);
    check8("midrst drop_cnt", drop_cnt, 8'h00);
    check8("midrst tx_data", tx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);
    run_frame("postrst", vecs[0].t1, vecs[0].t2);
    check_frame("postrst", 8'h00, vecs[0].b1, vecs[0].b2, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
